// File: rtl/mem_io_bridge.sv
// CPU-to-SRAM/IO bridge: one request at a time, async SRAM strobes with programmable
// wait states, and one memory-mapped IO word (switches in, hex display out).
module mem_io_bridge #(
  parameter int unsigned       ADDR_W      = 20,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       N_DIGITS    = 4,
  parameter int unsigned       WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 'hFFFF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  input  logic [DATA_W-1:0]     Switches,
  output logic [4*N_DIGITS-1:0] hex_digits,
  output logic                  CE,
  output logic                  UB,
  output logic                  LB,
  output logic                  OE,
  output logic                  WE,
  output logic [ADDR_W-1:0]     A,
  inout  wire  [DATA_W-1:0]     Data_Mem
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  drive_q, drive_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic [4*N_DIGITS-1:0] hex_q, hex_d;
  logic                  ce_q, ce_d;
  logic                  oe_q, oe_d;
  logic                  wen_q, wen_d;
  logic [ADDR_W-1:0]     a_q, a_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    drive_d = drive_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    hex_d   = hex_q;
    ce_d    = ce_q;
    oe_d    = oe_q;
    wen_d   = wen_q;
    a_d     = a_q;

    case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = we;
          wdata_d = wdata;
          if (addr == IO_ADDR) begin
            // IO word takes priority over the SRAM location with the same address.
            state_d = StDone;
            ready_d = 1'b1;
            if (we) begin
              hex_d = wdata;
            end else begin
              rdata_d = Switches;
            end
          end else begin
            state_d = StAccess;
            cnt_d   = WaitInit;
            a_d     = addr;
            ce_d    = 1'b0;
            if (we) begin
              wen_d   = 1'b0;
              drive_d = 1'b1;
            end else begin
              oe_d = 1'b0;
            end
          end
        end
      end

      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          ready_d = 1'b1;
          ce_d    = 1'b1;
          oe_d    = 1'b1;
          wen_d   = 1'b1;
          if (!we_q) begin
            rdata_d = Data_Mem;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StDone: begin
        // Write data was held through DONE; release the bus now.
        state_d = StIdle;
        drive_d = 1'b0;
      end

      default: begin
        state_d = StIdle;
        drive_d = 1'b0;
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        wen_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      drive_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      hex_q   <= '0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      wen_q   <= 1'b1;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      drive_q <= drive_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      hex_q   <= hex_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      wen_q   <= wen_d;
      a_q     <= a_d;
    end
  end

  assign rdata      = rdata_q;
  assign ready      = ready_q;
  assign hex_digits = hex_q;
  assign CE         = ce_q;
  assign UB         = ce_q;
  assign LB         = ce_q;
  assign OE         = oe_q;
  assign WE         = wen_q;
  assign A          = a_q;
  assign Data_Mem   = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed scenarios plus random traffic against a
// transaction-level memory/IO reference model and a simple async SRAM bus model.
module tb_mem_io_bridge;

  localparam int unsigned W      = 2;
  localparam logic [19:0] IO_A   = 20'h0FFFF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [19:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ready;
  logic [15:0] Switches = '0;
  logic [15:0] hex_digits;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] A;
  wire  [15:0] Data_Mem;

  mem_io_bridge #(
    .ADDR_W(20), .DATA_W(16), .N_DIGITS(4), .WAIT_STATES(W), .IO_ADDR(IO_A)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .Switches(Switches), .hex_digits(hex_digits),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .A(A), .Data_Mem(Data_Mem)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: completed writes only, plus display and last read value.
  logic [15:0] ref_mem [logic [19:0]];
  logic [15:0] hex_ref = '0;
  logic [15:0] rd_ref = '0;

  // Physical SRAM behind the bus: stores whatever is on the bus while WE is low.
  logic [15:0] phys_mem [logic [19:0]];
  logic [15:0] sram_out = '0;

  assign Data_Mem = (!CE && !OE) ? sram_out : 16'bz;

  always @(negedge Clk) begin
    if (!CE && !WE) phys_mem[A] = Data_Mem;
    sram_out = phys_mem.exists(A) ? phys_mem[A] : 16'h0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  always @(negedge Clk) chk("oe_we_exclusive", 32'(OE | WE), 32'd1);

  // Caller is in an IDLE cycle (#1 after an edge); returns #1 after the cycle following ready.
  task automatic do_txn(input bit wr, input logic [19:0] ad, input logic [15:0] wd,
                        input logic [15:0] sw);
    int cyc = 1;
    int we_lo = 0;
    int oe_lo = 0;
    bit seen = 0;
    bit io;
    logic [15:0] exp_rd;
    io = (ad == IO_A);
    req = 1'b1; we = wr; addr = ad; wdata = wd; Switches = sw;
    @(posedge Clk); #1;
    // Scramble inputs so the bench notices anything not latched at acceptance.
    req = 1'b0; we = 1'($urandom); addr = 20'($urandom); wdata = 16'($urandom);
    Switches = 16'($urandom);
    while (cyc <= 40) begin
      if (ready) begin
        seen = 1;
        break;
      end
      if (!WE) begin
        we_lo++;
        chk("write_bus_data", 32'(Data_Mem), 32'(wd));
      end
      if (!OE) oe_lo++;
      chk(io ? "io_strobes_idle" : "sram_enables_low", 32'({CE, UB, LB}), io ? 32'h7 : 32'h0);
      if (!io) chk("sram_addr", 32'(A), 32'(ad));
      @(posedge Clk); #1;
      cyc++;
    end
    chk("ready_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc), io ? 32'd1 : 32'(W + 2));
    chk("done_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    chk("we_low_cycles", 32'(we_lo), (wr && !io) ? 32'(W + 1) : 32'd0);
    chk("oe_low_cycles", 32'(oe_lo), (!wr && !io) ? 32'(W + 1) : 32'd0);
    if (wr) begin
      if (io) hex_ref = wd;
      else begin
        ref_mem[ad] = wd;
        chk("write_data_hold", 32'(Data_Mem), 32'(wd));
      end
    end else begin
      exp_rd = io ? sw : ref_rd(ad);
      rd_ref = exp_rd;
    end
    chk("rdata", 32'(rdata), 32'(rd_ref));
    chk("hex_digits", 32'(hex_digits), 32'(hex_ref));
    @(posedge Clk); #1;
    chk("ready_one_cycle", 32'(ready), 32'd0);
    chk("rdata_held", 32'(rdata), 32'(rd_ref));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rdy_cnt;
    int rdy_c[2];

    // 1. Reset and idle
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    chk("reset_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_hex", 32'(hex_digits), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_addr", 32'(A), 32'd0);

    // 2-3. SRAM write then read back
    do_txn(1'b1, 20'h00010, 16'hBEEF, 16'h0000);
    do_txn(1'b0, 20'h00010, 16'h0000, 16'h0000);

    // 4. IO write and read; plus a non-IO address sharing IO_ADDR's low bits
    do_txn(1'b1, IO_A, 16'h1234, 16'h0000);
    do_txn(1'b0, IO_A, 16'h0000, 16'hA5C3);
    do_txn(1'b1, 20'h1FFFF, 16'h5A5A, 16'h0000);
    do_txn(1'b0, 20'h1FFFF, 16'h0000, 16'hFFFF);
    chk("hex_after_sram", 32'(hex_digits), 32'h1234);

    // 5. req held high across two reads: second request only after DONE
    rdy_cnt = 0;
    req = 1'b1; we = 1'b0; addr = 20'h00010;
    for (int c = 1; c <= 2 * W + 10; c++) begin
      @(posedge Clk); #1;
      if (ready) begin
        if (rdy_cnt < 2) rdy_c[rdy_cnt] = c;
        rdy_cnt++;
        chk("held_rdata", 32'(rdata), 32'hBEEF);
        if (rdy_cnt == 2) req = 1'b0;
      end
    end
    req = 1'b0;
    chk("held_ready_count", 32'(rdy_cnt), 32'd2);
    chk("held_first_ready", 32'(rdy_c[0]), 32'(W + 2));
    chk("held_second_ready", 32'(rdy_c[1]), 32'(2 * W + 5));
    rd_ref = 16'hBEEF;

    // 6. Reset during the second ACCESS cycle of a write
    req = 1'b1; we = 1'b1; addr = 20'h00020; wdata = 16'h7777;
    @(posedge Clk); #1;
    req = 1'b0;
    @(posedge Clk); #1;
    chk("abort_in_access", 32'(WE), 32'd0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("abort_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_addr", 32'(A), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    chk("abort_hex", 32'(hex_digits), 32'd0);
    hex_ref = '0;
    rd_ref = '0;
    rdy_cnt = 0;
    repeat (2 * W + 4) begin
      @(posedge Clk); #1;
      if (ready) rdy_cnt++;
    end
    chk("abort_no_ready", 32'(rdy_cnt), 32'd0);
    do_txn(1'b0, 20'h00010, 16'h0000, 16'h0000);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      bit wr;
      bit io;
      logic [19:0] ad;
      wr = 1'($urandom_range(0, 1));
      io = ($urandom_range(0, 4) == 0);
      ad = io ? IO_A : (20'($urandom) & 20'hF000F);
      do_txn(wr, ad, 16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
